// File: rtl/video_types.sv
// Shared video types for the LCD pipeline.
// Holds the OAM scan constants, the per-line sprite record and the scanner
// state encoding, plus the sprite vertical hit test used during OAM scan.
package video_types;

  localparam int unsigned OAM_ENTRIES      = 40;
  localparam int unsigned MAX_LINE_SPRITES = 10;
  localparam int unsigned SPRITE_Y_OFFSET  = 16;

  // Address of the last byte read during a scan: XPosition of entry 39.
  localparam logic [7:0] OAM_LAST_ADDR = 8'(4 * (OAM_ENTRIES - 1) + 1);

  typedef struct packed {
    logic [5:0] OamIndex;
    logic [7:0] XPosition;
  } LineSprite;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_t;

  // Sprite covers the line iff 0 <= ly + 16 - ypos < height.
  // Evaluated 10 bits wide so neither the +16 nor the subtraction can wrap.
  function automatic logic sprite_hit(input logic [7:0] line,
                                      input logic [7:0] ypos,
                                      input logic       tall);
    logic signed [9:0] diff;
    logic signed [9:0] height;
    diff   = $signed({2'b00, line}) + $signed(10'(SPRITE_Y_OFFSET))
             - $signed({2'b00, ypos});
    height = tall ? 10'sd16 : 10'sd8;
    return (diff >= 10'sd0) && (diff < height);
  endfunction

endpackage

// File: rtl/oam_scanner.sv
// OAM scanner (LCD mode 2).
// On a start pulse it reads YPosition/XPosition of all 40 OAM entries in
// ascending order and keeps the first 10 entries that cover the latched line.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle pulse at the start of mode 2 (IDLE only)
//   ly, sprite_size,
//   sprite_enable     : line and LCDC bits, latched at start
//   oam_rd, oam_addr  : OAM read strobe / byte address (0 when not reading)
//   oam_data          : OAM read data, valid the cycle after oam_rd
//   busy, done        : scan in progress / one-cycle completion pulse
//   count             : number of sprites selected (0..10)
//   sel_idx           : buffer slot to read back
//   sel_index, sel_x  : OAM entry number and XPosition of slot sel_idx
module oam_scanner
  import video_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ly,
  input  logic       sprite_size,
  input  logic       sprite_enable,
  output logic       oam_rd,
  output logic [7:0] oam_addr,
  input  logic [7:0] oam_data,
  output logic       busy,
  output logic       done,
  output logic [3:0] count,
  input  logic [3:0] sel_idx,
  output logic [5:0] sel_index,
  output logic [7:0] sel_x
);

  scan_state_t r_state;
  logic        r_rd;
  logic [7:0]  r_addr;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_count;
  LineSprite   r_buf [MAX_LINE_SPRITES];

  logic [7:0]  r_ly;
  logic        r_tall;
  logic        r_en;
  logic [7:0]  r_ypos;

  // Describes the byte arriving on oam_data this cycle (issued last cycle).
  logic        r_pend_valid;
  logic        r_pend_x;
  logic [5:0]  r_pend_idx;

  logic        w_hit;

  assign w_hit = sprite_hit(r_ly, r_ypos, r_tall);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rd         <= 1'b0;
      r_addr       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_count      <= '0;
      r_ly         <= '0;
      r_tall       <= 1'b0;
      r_en         <= 1'b0;
      r_ypos       <= '0;
      r_pend_valid <= 1'b0;
      r_pend_x     <= 1'b0;
      r_pend_idx   <= '0;
      for (int unsigned s = 0; s < MAX_LINE_SPRITES; s++) begin
        r_buf[s] <= '0;
      end
    end else begin
      r_pend_valid <= r_rd;
      r_pend_x     <= r_addr[0];
      r_pend_idx   <= r_addr[7:2];

      // Y bytes are held for one cycle; the entry is judged when X arrives.
      if (r_pend_valid) begin
        if (!r_pend_x) begin
          r_ypos <= oam_data;
        end else if (r_en && w_hit && (r_count < 4'(MAX_LINE_SPRITES))) begin
          for (int unsigned s = 0; s < MAX_LINE_SPRITES; s++) begin
            if (r_count == 4'(s)) begin
              r_buf[s] <= '{OamIndex: r_pend_idx, XPosition: oam_data};
            end
          end
          r_count <= r_count + 4'd1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SCAN;
            r_ly    <= ly;
            r_tall  <= sprite_size;
            r_en    <= sprite_enable;
            r_count <= '0;
            r_rd    <= 1'b1;
            r_addr  <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (r_addr == OAM_LAST_ADDR) begin
            r_state <= ST_DRAIN;
            r_rd    <= 1'b0;
            r_addr  <= '0;
          end else begin
            // Y at 4i, X at 4i+1: step +1 from Y to X, +3 from X to next Y.
            r_addr <= r_addr[0] ? r_addr + 8'd3 : r_addr + 8'd1;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sel_index = '0;
    sel_x     = '0;
    for (int unsigned s = 0; s < MAX_LINE_SPRITES; s++) begin
      if ((sel_idx == 4'(s)) && (sel_idx < r_count)) begin
        sel_index = r_buf[s].OamIndex;
        sel_x     = r_buf[s].XPosition;
      end
    end
  end

  assign oam_rd   = r_rd;
  assign oam_addr = r_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;

endmodule

// File: tb/tb_oam_scanner.sv
module tb_oam_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] ly;
  logic       sprite_size;
  logic       sprite_enable;
  logic       oam_rd;
  logic [7:0] oam_addr;
  logic [7:0] oam_data;
  logic       busy;
  logic       done;
  logic [3:0] count;
  logic [3:0] sel_idx;
  logic [5:0] sel_index;
  logic [7:0] sel_x;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] mem [160];

  // Reference results
  int         m_n;
  int         m_idx [10];
  int         m_x   [10];

  oam_scanner dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .ly            (ly),
    .sprite_size   (sprite_size),
    .sprite_enable (sprite_enable),
    .oam_rd        (oam_rd),
    .oam_addr      (oam_addr),
    .oam_data      (oam_data),
    .busy          (busy),
    .done          (done),
    .count         (count),
    .sel_idx       (sel_idx),
    .sel_index     (sel_index),
    .sel_x         (sel_x)
  );

  always #5 clk = ~clk;

  // OAM memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (oam_rd) oam_data <= (oam_addr < 8'd160) ? mem[oam_addr] : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the 40 entries, keep the first ten whose line range covers l.
  task automatic compute_model(input logic [7:0] l, input logic sz, input logic en);
    int d;
    int h;
    m_n = 0;
    h = sz ? 16 : 8;
    for (int e = 0; e < 40; e++) begin
      d = int'(l) + 16 - int'(mem[8'(4 * e)]);
      if (en && d >= 0 && d < h && m_n < 10) begin
        m_idx[m_n] = e;
        m_x[m_n]   = int'(mem[8'(4 * e + 1)]);
        m_n++;
      end
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_n));
    for (int s = 0; s < 16; s++) begin
      sel_idx = 4'(s);
      #1;
      if (s < m_n) begin
        check($sformatf("%s.idx%0d", tag, s), 32'(sel_index), 32'(m_idx[s]));
        check($sformatf("%s.x%0d", tag, s),   32'(sel_x),     32'(m_x[s]));
      end else begin
        check($sformatf("%s.idx%0d", tag, s), 32'(sel_index), 32'd0);
        check($sformatf("%s.x%0d", tag, s),   32'(sel_x),     32'd0);
      end
    end
    sel_idx = 4'd0;
  endtask

  // One full scan; restart_at > 0 pulses start again (with altered inputs)
  // in that cycle of the scan.
  task automatic run_scan(input string tag, input logic [7:0] l, input logic sz,
                          input logic en, input int restart_at);
    int cyc;
    int reads;
    int bad_addr;
    int bad_busy;
    int exp_addr;
    bit got;
    @(posedge clk); #1;
    ly = l; sprite_size = sz; sprite_enable = en; start = 1'b1;
    cyc = 0; reads = 0; bad_addr = 0; bad_busy = 0; got = 1'b0;
    while (cyc < 200 && !got) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == restart_at);
      if (cyc == restart_at) begin
        ly = ~l; sprite_size = ~sz; sprite_enable = ~en;
      end
      if (oam_rd) begin
        exp_addr = 4 * (reads / 2) + (reads % 2);
        if (int'(oam_addr) != exp_addr) bad_addr++;
        reads++;
      end else if (oam_addr !== 8'd0) begin
        bad_addr++;
      end
      if (cyc < 82 && (busy !== 1'b1 || done !== 1'b0)) bad_busy++;
      if (done === 1'b1) got = 1'b1;
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 32'(got), 32'd1);
    check({tag, ".done_cycle"}, 32'(cyc), 32'd82);
    check({tag, ".reads"}, 32'(reads), 32'd80);
    check({tag, ".addr_errs"}, 32'(bad_addr), 32'd0);
    check({tag, ".busy_errs"}, 32'(bad_busy), 32'd0);
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(done), 32'd0);
    compute_model(l, sz, en);
  endtask

  task automatic fill(input logic [7:0] y, input logic [7:0] x);
    for (int e = 0; e < 40; e++) begin
      mem[8'(4 * e)]     = y;
      mem[8'(4 * e + 1)] = x;
      mem[8'(4 * e + 2)] = 8'h00;
      mem[8'(4 * e + 3)] = 8'h00;
    end
  endtask

  initial begin
    int l;
    reset = 1'b1; start = 1'b0; ly = '0; sprite_size = 1'b0;
    sprite_enable = 1'b1; sel_idx = '0;
    for (int i = 0; i < 160; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst.rd",    32'(oam_rd),    32'd0);
    check("rst.addr",  32'(oam_addr),  32'd0);
    check("rst.busy",  32'(busy),      32'd0);
    check("rst.done",  32'(done),      32'd0);
    check("rst.count", 32'(count),     32'd0);
    check("rst.sel",   32'({sel_index, sel_x}), 32'd0);
    reset = 1'b0;

    // All-zero OAM, line 0: Y=0 gives diff 16, nothing fits.
    fill(8'h00, 8'h00);
    run_scan("zero", 8'd0, 1'b0, 1'b1, 0);
    check("zero.count_const", 32'(count), 32'd0);
    check_results("zero");

    // Entries 3 and 7 on line 0.
    mem[12] = 8'd16; mem[13] = 8'h20;
    mem[28] = 8'd16; mem[29] = 8'h30;
    run_scan("two", 8'd0, 1'b0, 1'b1, 0);
    check("two.count_const", 32'(count), 32'd2);
    check_results("two");

    // Height boundaries around Y=10.
    fill(8'd200, 8'h55);
    mem[0] = 8'd10; mem[1] = 8'h11;
    run_scan("y10_l9_s8",  8'd9, 1'b0, 1'b1, 0); check_results("y10_l9_s8");
    run_scan("y10_l9_s16", 8'd9, 1'b1, 1'b1, 0); check_results("y10_l9_s16");
    run_scan("y10_l2_s8",  8'd2, 1'b0, 1'b1, 0); check_results("y10_l2_s8");
    run_scan("y10_l1_s8",  8'd1, 1'b0, 1'b1, 0); check_results("y10_l1_s8");
    run_scan("y10_l10_s16", 8'd10, 1'b1, 1'b1, 0); check_results("y10_l10_s16");

    // Every entry hits; only the first ten are kept. X varies incl. 0 and >=168.
    fill(8'd16, 8'h00);
    for (int e = 0; e < 40; e++) mem[8'(4 * e + 1)] = 8'(e * 7);
    mem[5] = 8'd200;
    run_scan("all", 8'd0, 1'b0, 1'b1, 0);
    check("all.count_const", 32'(count), 32'd10);
    check_results("all");

    // Held stable after done while inputs wiggle.
    repeat (5) @(posedge clk);
    #1; ly = 8'd77; sprite_size = 1'b1; sprite_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_results("hold");

    // Reset in cycle 30 of a scan.
    @(posedge clk); #1;
    ly = 8'd0; sprite_size = 1'b0; sprite_enable = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (29) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("midrst.rd",    32'(oam_rd),   32'd0);
    check("midrst.addr",  32'(oam_addr), 32'd0);
    check("midrst.busy",  32'(busy),     32'd0);
    check("midrst.done",  32'(done),     32'd0);
    check("midrst.count", 32'(count),    32'd0);
    run_scan("after_rst", 8'd0, 1'b0, 1'b1, 0);
    check_results("after_rst");

    // Reset wins over a simultaneous start.
    @(posedge clk); #1; reset = 1'b1; start = 1'b1;
    @(posedge clk); #1; reset = 1'b0; start = 1'b0;
    check("rst_start.busy",  32'(busy),   32'd0);
    check("rst_start.rd",    32'(oam_rd), 32'd0);
    check("rst_start.count", 32'(count),  32'd0);
    @(posedge clk); #1;
    check("rst_start.busy2", 32'(busy),   32'd0);

    // Second start mid-scan is ignored, original latched values used.
    fill(8'd30, 8'h42);
    for (int e = 0; e < 40; e += 3) mem[8'(4 * e)] = 8'd20;
    run_scan("restart", 8'd10, 1'b0, 1'b1, 20);
    check_results("restart");

    // Sprites disabled: all entries would hit, none recorded.
    fill(8'd16, 8'h99);
    run_scan("disabled", 8'd0, 1'b1, 1'b0, 0);
    check("disabled.count_const", 32'(count), 32'd0);
    check_results("disabled");

    // Random OAM contents clustered around the chosen line.
    for (int r = 0; r < 8; r++) begin
      l = int'($urandom_range(0, 255));
      for (int e = 0; e < 40; e++) begin
        if ($urandom_range(0, 3) == 0)
          mem[8'(4 * e)] = 8'($urandom);
        else
          mem[8'(4 * e)] = 8'(l + 16 - int'($urandom_range(0, 24)));
        mem[8'(4 * e + 1)] = 8'($urandom);
      end
      run_scan($sformatf("rnd%0d", r), 8'(l), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) != 0), 0);
      check_results($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
